twiddle_mult_4_3: RTL and testbench
===================================

Name: twiddle_mult_4_3

Overview:
- Stage-4 twiddle multiplier: consumes the 22-bit packed coefficient stream from the stage-4/3 coefficient ROM and one complex data sample per valid cycle.
- Outputs the rounded, saturated complex product to the next butterfly stage.
- Tracks position within the 32-sample coefficient frame and flags frame misalignment and saturation.
- Fully streaming 3-stage pipeline, no backpressure.

Parameters:
- DATA_W, 16, width of each real/imag data component (signed two's complement).
- COEFF_W, 11, width of each real/imag coefficient component (signed Q1.9).
- COEFF_FRAC, 9, fractional bits of the coefficient; product shift amount.
- FRAME_LEN, 32, samples per coefficient frame; must equal the ROM depth.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  data sample present this cycle.
- frame_start  in  1  marks the first sample of a frame; sampled only when in_valid=1.
- din  in  2*DATA_W  complex sample, [2*DATA_W-1:DATA_W]=real, [DATA_W-1:0]=imag.
- coeff_in  in  2*COEFF_W  packed coefficient from ROM, [21:11]=real, [10:0]=imag.
- out_valid  out  1  dout valid.
- out_last  out  1  asserted with the output of frame sample FRAME_LEN-1.
- dout  out  2*DATA_W  complex product, same packing as din.
- sat_flag  out  1  sticky: any output component saturated.
- frame_err  out  1  sticky: frame_start seen while the frame counter was nonzero.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid, out_last, dout, sat_flag, frame_err, all pipeline valids/data and the frame counter go to 0 immediately. Reset asserted mid-frame discards all in-flight samples; the first output after release comes only from samples accepted after release.
- S1 (input register), on in_valid=1:
  - Capture din and coeff_in.
  - Capture idx = frame counter value, or 0 if frame_start=1.
  - Valid bit follows in_valid; data registers hold when invalid.
- Frame counter (log2(FRAME_LEN) bits) advances only on in_valid:
  - frame_start=1: next = 1; if the current counter != 0, set frame_err (resync wins, count restarts).
  - otherwise: next = counter+1, wrapping FRAME_LEN-1 -> 0.
  - in_valid=0: counter holds.
- S2 (products): four signed products ar*br, ai*bi, ar*bi, ai*br, each DATA_W+COEFF_W = 27 bits, registered.
- S3 (combine and output register):
  - re = ar*br - ai*bi, im = ar*bi + ai*br, each 28 bits.
  - Round half-up: add 2^(COEFF_FRAC-1), then arithmetic shift right by COEFF_FRAC.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register into dout. Set sat_flag if either component clipped on a valid sample.
- Latency: exactly 3 clocks from an in_valid sample to its out_valid. Throughput is 1 sample/clock.
- Output timing and holds:
  - out_valid is the in_valid pipeline delayed by 3.
  - out_last = out_valid & (idx == FRAME_LEN-1).
  - dout holds its last value while out_valid=0.
- Coefficient alignment: the upstream ROM steps every clock, so coeff_in is sampled on the same edge as din. The system guarantees the ROM index equals the sample index. This block does not re-time coefficients.
- Simultaneous events:
  - frame_start with in_valid=0 is ignored.
  - sat_flag and frame_err clear only by reset.
  - frame_start on the cycle the counter wraps to 0 is legal and does not set frame_err.

Decomposition:
- Shared fft package holds:
  - DATA_W, COEFF_W, COEFF_FRAC, FRAME_LEN constants;
  - complex pack/unpack field positions;
  - the round-and-saturate function, reused by every stage multiplier.
- One natural sub-module: cmplx_mult_pipe (S2+S3 arithmetic, valid pass-through). The top level adds S1, the frame counter, idx tracking and the flags.

Test Plan:
- Identity: coeff re=512, im=0 (1.0); din=(1000, 2000), in_valid pulse -> 3 cycles later out_valid=1, dout=(1000, 2000), sat_flag=0.
- Rotation by -j: coeff re=0, im=-512; din=(1000, 2000) -> dout=(2000, -1000).
- Rounding: coeff re=256 (0.5), im=0; din re=3 -> dout re=2; din re=-3 -> dout re=-1.
- Saturation: coeff re=-1024 (-2.0), im=0; din=(20000, -20000) -> dout=(-32768, 32767); sat_flag=1 and stays 1.
- Framing:
  - frame_start with sample 0, then 32 consecutive valid samples -> out_last=1 only on the 32st output, 3 cycles after the last input, and frame_err=0.
  - A second frame_start at sample 10 -> frame_err=1; out_last then appears 31 samples later.
- Reset mid-stream: drop rst_n while 2 samples are in flight -> out_valid, dout and flags go to 0 asynchronously; no stale output after release.

Source files
------------

// File: rtl/twiddle_mult_4_3_pkg.sv
// Shared definitions for the stage-4 twiddle multiplier.
// Holds the datapath widths, the frame length, the complex field positions
// with pack/unpack helpers, and the round-and-saturate function that every
// stage multiplier uses to bring a full-precision product back to DATA_W.
package twiddle_mult_4_3_pkg;

    localparam int DATA_W     = 16;
    localparam int COEFF_W    = 11;
    localparam int COEFF_FRAC = 9;
    localparam int FRAME_LEN  = 32;

    localparam int CNT_W  = $clog2(FRAME_LEN);
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int ACC_W  = PROD_W + 1;

    // Packed complex words carry the real part in the upper half.
    localparam int DIN_RE_MSB   = 2*DATA_W - 1;
    localparam int DIN_RE_LSB   = DATA_W;
    localparam int DIN_IM_MSB   = DATA_W - 1;
    localparam int DIN_IM_LSB   = 0;
    localparam int COEFF_RE_MSB = 2*COEFF_W - 1;
    localparam int COEFF_RE_LSB = COEFF_W;
    localparam int COEFF_IM_MSB = COEFF_W - 1;
    localparam int COEFF_IM_LSB = 0;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [COEFF_W-1:0] re;
        logic signed [COEFF_W-1:0] im;
    } coeff_t;

    typedef struct packed {
        logic                     clip;
        logic signed [DATA_W-1:0] val;
    } rs_t;

    // Half-LSB of the output grid, expressed at accumulator scale.
    localparam logic signed [ACC_W:0] RND_BIAS =
        {{(ACC_W+1-COEFF_FRAC){1'b0}}, 1'b1, {(COEFF_FRAC-1){1'b0}}};
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

    function automatic cplx_t unpack_cplx(input logic [2*DATA_W-1:0] v);
        cplx_t c;
        c.re = v[DIN_RE_MSB:DIN_RE_LSB];
        c.im = v[DIN_IM_MSB:DIN_IM_LSB];
        return c;
    endfunction

    function automatic logic [2*DATA_W-1:0] pack_cplx(input cplx_t c);
        return {c.re, c.im};
    endfunction

    function automatic coeff_t unpack_coeff(input logic [2*COEFF_W-1:0] v);
        coeff_t c;
        c.re = v[COEFF_RE_MSB:COEFF_RE_LSB];
        c.im = v[COEFF_IM_MSB:COEFF_IM_LSB];
        return c;
    endfunction

    // Round half-up, drop COEFF_FRAC bits, clamp to the DATA_W range.
    // One guard bit above the accumulator keeps the bias add from wrapping.
    function automatic rs_t round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] biased;
        logic signed [ACC_W:0] shifted;
        rs_t                   r;
        biased  = {acc[ACC_W-1], acc} + RND_BIAS;
        shifted = biased >>> COEFF_FRAC;
        r.clip  = 1'b0;
        r.val   = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            r.clip = 1'b1;
            r.val  = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            r.clip = 1'b1;
            r.val  = {1'b1, {(DATA_W-1){1'b0}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/twiddle_mult_4_3_if.sv
// Streaming bus of the stage-4 twiddle multiplier.
//   in_valid, frame_start : sample strobe and frame marker
//   din, coeff_in         : packed complex sample and ROM coefficient
//   out_valid, out_last   : result strobe and end-of-frame marker
//   dout                  : packed complex result
//   sat_flag, frame_err   : sticky status
// master drives samples in; slave is the multiplier.
interface twiddle_mult_4_3_if;
    import twiddle_mult_4_3_pkg::*;

    logic                   in_valid;
    logic                   frame_start;
    logic [2*DATA_W-1:0]    din;
    logic [2*COEFF_W-1:0]   coeff_in;
    logic                   out_valid;
    logic                   out_last;
    logic [2*DATA_W-1:0]    dout;
    logic                   sat_flag;
    logic                   frame_err;

    modport master (
        output in_valid, frame_start, din, coeff_in,
        input  out_valid, out_last, dout, sat_flag, frame_err
    );

    modport slave (
        input  in_valid, frame_start, din, coeff_in,
        output out_valid, out_last, dout, sat_flag, frame_err
    );

endinterface

// File: rtl/twiddle_mult_4_3_cmplx_mult_pipe.sv
// Two-stage complex multiply: registered partial products, then combine,
// round, saturate and register the result. The valid bit rides alongside.
//   clk, rst_n    : clock, async active-low reset
//   vld_p0        : input sample valid (already registered upstream)
//   a_p0, b_p0    : complex sample and coefficient
//   vld_p2, y_p2  : result valid and rounded/saturated product
//   sat_hit       : a valid result is being clipped on this edge
module twiddle_mult_4_3_cmplx_mult_pipe
    import twiddle_mult_4_3_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   vld_p0,
    input  cplx_t  a_p0,
    input  coeff_t b_p0,
    output logic   vld_p2,
    output cplx_t  y_p2,
    output logic   sat_hit
);

    logic signed [DATA_W-1:0]  ar_p0;
    logic signed [DATA_W-1:0]  ai_p0;
    logic signed [COEFF_W-1:0] br_p0;
    logic signed [COEFF_W-1:0] bi_p0;

    logic                      vld_p1;
    logic signed [PROD_W-1:0]  prod_rr_p1;
    logic signed [PROD_W-1:0]  prod_ii_p1;
    logic signed [PROD_W-1:0]  prod_ri_p1;
    logic signed [PROD_W-1:0]  prod_ir_p1;

    logic signed [ACC_W-1:0]   acc_re;
    logic signed [ACC_W-1:0]   acc_im;
    rs_t                       rs_re;
    rs_t                       rs_im;

    assign ar_p0 = a_p0.re;
    assign ai_p0 = a_p0.im;
    assign br_p0 = b_p0.re;
    assign bi_p0 = b_p0.im;

    // ---- p0 -> p1: partial products ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            prod_rr_p1 <= '0;
            prod_ii_p1 <= '0;
            prod_ri_p1 <= '0;
            prod_ir_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                prod_rr_p1 <= PROD_W'(ar_p0) * PROD_W'(br_p0);
                prod_ii_p1 <= PROD_W'(ai_p0) * PROD_W'(bi_p0);
                prod_ri_p1 <= PROD_W'(ar_p0) * PROD_W'(bi_p0);
                prod_ir_p1 <= PROD_W'(ai_p0) * PROD_W'(br_p0);
            end
        end
    end

    assign acc_re  = ACC_W'(prod_rr_p1) - ACC_W'(prod_ii_p1);
    assign acc_im  = ACC_W'(prod_ri_p1) + ACC_W'(prod_ir_p1);
    assign rs_re   = round_sat(acc_re);
    assign rs_im   = round_sat(acc_im);
    assign sat_hit = vld_p1 & (rs_re.clip | rs_im.clip);

    // ---- p1 -> p2: combine, round, saturate ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            y_p2   <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                y_p2.re <= rs_re.val;
                y_p2.im <= rs_im.val;
            end
        end
    end

endmodule

// File: rtl/twiddle_mult_4_3.sv
// Stage-4 twiddle multiplier. Registers each complex sample together with
// its ROM coefficient, multiplies them through a streaming pipeline, and
// tracks the sample's position in the coefficient frame so the final sample
// of each frame can be marked. Three clocks from input to output.
//   clk    : clock
//   rst_n  : async active-low reset
//   bus    : streaming bus (see twiddle_mult_4_3_if), slave side
module twiddle_mult_4_3
    import twiddle_mult_4_3_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    twiddle_mult_4_3_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] idx_c;

    logic             vld_p0;
    cplx_t            din_p0;
    coeff_t           coeff_p0;
    logic             last_p0;
    logic             last_p1;
    logic             last_p2;

    logic             vld_p2;
    cplx_t            dout_p2;
    logic             sat_hit;
    logic             sat_flag_q;
    logic             frame_err_q;

    // A frame_start resynchronises the sample onto index 0.
    assign idx_c = bus.frame_start ? '0 : frame_cnt;

    // ---- input -> p0: sample, coefficient and frame position ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0   <= 1'b0;
            din_p0   <= '0;
            coeff_p0 <= '0;
            last_p0  <= 1'b0;
        end else begin
            vld_p0 <= bus.in_valid;
            if (bus.in_valid) begin
                din_p0   <= unpack_cplx(bus.din);
                coeff_p0 <= unpack_coeff(bus.coeff_in);
                last_p0  <= (idx_c == LAST_IDX);
            end
        end
    end

    // Frame counter holds the index the next sample will take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            frame_err_q <= 1'b0;
        end else if (bus.in_valid) begin
            if (bus.frame_start) begin
                frame_cnt <= CNT_W'(1);
                if (frame_cnt != '0) begin
                    frame_err_q <= 1'b1;
                end
            end else if (frame_cnt == LAST_IDX) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    twiddle_mult_4_3_cmplx_mult_pipe u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld_p0  (vld_p0),
        .a_p0    (din_p0),
        .b_p0    (coeff_p0),
        .vld_p2  (vld_p2),
        .y_p2    (dout_p2),
        .sat_hit (sat_hit)
    );

    // ---- p0 -> p2: end-of-frame marker follows the multiplier ----
    // last_p1 is qualified by vld_p0, so an idle slot always clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_p1    <= 1'b0;
            last_p2    <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            last_p1    <= vld_p0 & last_p0;
            last_p2    <= last_p1;
            sat_flag_q <= sat_flag_q | sat_hit;
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_last  = last_p2;
    assign bus.dout      = pack_cplx(dout_p2);
    assign bus.sat_flag  = sat_flag_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_twiddle_mult_4_3.sv
module tb_twiddle_mult_4_3;
    import twiddle_mult_4_3_pkg::*;

    logic clk;
    logic rst_n;

    twiddle_mult_4_3_if bus();

    twiddle_mult_4_3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Reference model state
    typedef struct {
        bit vld;
        bit last;
        bit clip;
        int re;
        int im;
    } ent_t;

    ent_t line [3];
    ent_t e_new;
    int   m_cnt, m_pos;
    bit   m_err, m_sat, m_ov, m_ol;
    int   m_re, m_im;

    // Monitor counters
    int out_total = 0;
    int last_cnt  = 0;
    int last_at   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Floor division rounding with clamp to 16-bit signed.
    function automatic int rnd_sat(input int x, output bit clip);
        int r, q;
        r = x + 256;
        q = r / 512;
        if ((r % 512) != 0 && r < 0) q = q - 1;
        clip = 1'b0;
        if (q > 32767) begin
            q = 32767;
            clip = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            clip = 1'b1;
        end
        return q;
    endfunction

    task automatic model_step();
        int ar, ai, br, bi;
        bit c1, c2;
        if (!rst_n) begin
            m_cnt = 0; m_err = 0; m_sat = 0; m_ov = 0; m_ol = 0;
            m_re = 0; m_im = 0;
            for (int i = 0; i < 3; i++) line[i] = '{default: 0};
        end else begin
            e_new = '{default: 0};
            if (bus.in_valid === 1'b1) begin
                if (bus.frame_start === 1'b1) begin
                    if (m_cnt != 0) m_err = 1;
                    m_pos = 0;
                end else begin
                    m_pos = m_cnt;
                end
                m_cnt = (m_pos + 1) % FRAME_LEN;
                ar = $signed(bus.din[31:16]);
                ai = $signed(bus.din[15:0]);
                br = $signed(bus.coeff_in[21:11]);
                bi = $signed(bus.coeff_in[10:0]);
                e_new.vld  = 1;
                e_new.last = (m_pos == FRAME_LEN - 1);
                e_new.re   = rnd_sat(ar * br - ai * bi, c1);
                e_new.im   = rnd_sat(ar * bi + ai * br, c2);
                e_new.clip = c1 | c2;
            end
            line[2] = line[1];
            line[1] = line[0];
            line[0] = e_new;
            m_ov = line[2].vld;
            m_ol = line[2].vld & line[2].last;
            if (line[2].vld) begin
                m_re = line[2].re;
                m_im = line[2].im;
                if (line[2].clip) m_sat = 1;
            end
        end
    endtask

    task automatic drive(input bit v, input bit fs, input int re, input int im,
                         input int cre, input int cim);
        @(posedge clk);
        #1;
        bus.in_valid    = v;
        bus.frame_start = fs;
        bus.din         = {16'(re), 16'(im)};
        bus.coeff_in    = {11'(cre), 11'(cim)};
    endtask

    task automatic single(input string nm, input bit fs, input int re, input int im,
                          input int cre, input int cim, input int exp_re, input int exp_im);
        drive(1, fs, re, im, cre, cim);
        drive(0, 0, 0, 0, cre, cim);
        @(posedge clk); #1;
        check({nm, " early_valid"}, {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk); #1;
        check({nm, " out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({nm, " dout"}, bus.dout, {16'(exp_re), 16'(exp_im)});
    endtask

    initial begin
        int base, lbase;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b0;
        bus.din         = '0;
        bus.coeff_in    = '0;

        fork
            forever begin
                @(posedge clk or negedge rst_n);
                model_step();
            end
            forever begin
                @(negedge clk);
                if (rst_n && bus.out_valid) begin
                    out_total++;
                    if (bus.out_last) begin
                        last_cnt++;
                        last_at = out_total;
                    end
                end
                if (chk_en) begin
                    check("m out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
                    check("m out_last", {31'd0, bus.out_last}, {31'd0, m_ol});
                    check("m dout", bus.dout, {16'(m_re), 16'(m_im)});
                    check("m sat_flag", {31'd0, bus.sat_flag}, {31'd0, m_sat});
                    check("m frame_err", {31'd0, bus.frame_err}, {31'd0, m_err});
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst out_last", {31'd0, bus.out_last}, 32'd0);
        check("rst dout", bus.dout, 32'd0);
        check("rst sat_flag", {31'd0, bus.sat_flag}, 32'd0);
        check("rst frame_err", {31'd0, bus.frame_err}, 32'd0);
        rst_n = 1'b1;

        single("identity", 1, 1000, 2000, 512, 0, 1000, 2000);
        check("identity sat_flag", {31'd0, bus.sat_flag}, 32'd0);
        single("rot_minus_j", 0, 1000, 2000, 0, -512, 2000, -1000);
        single("round_pos", 0, 3, 0, 256, 0, 2, 0);
        single("round_neg", 0, -3, 0, 256, 0, -1, 0);
        single("saturate", 0, 20000, -20000, -1024, 0, -32768, 32767);
        check("saturate sat_flag", {31'd0, bus.sat_flag}, 32'd1);
        single("after_sat", 0, 5, 7, 512, 0, 5, 7);
        check("sticky sat_flag", {31'd0, bus.sat_flag}, 32'd1);
        check("no frame_err", {31'd0, bus.frame_err}, 32'd0);

        // Reset with two samples in flight
        drive(1, 0, 1234, -4321, 512, 0);
        drive(1, 0, -77, 88, 512, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("async dout", bus.dout, 32'd0);
        check("async sat_flag", {31'd0, bus.sat_flag}, 32'd0);
        check("async frame_err", {31'd0, bus.frame_err}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        base = out_total;
        repeat (6) drive(0, 0, 0, 0, 0, 0);
        check("no stale output", 32'(out_total - base), 32'd0);

        // One aligned frame
        base  = out_total;
        lbase = last_cnt;
        for (int i = 0; i < 32; i++) drive(1, i == 0, i * 10, -i, 512, 0);
        repeat (5) drive(0, 0, 0, 0, 0, 0);
        check("frame1 outputs", 32'(out_total - base), 32'd32);
        check("frame1 last count", 32'(last_cnt - lbase), 32'd1);
        check("frame1 last position", 32'(last_at - base), 32'd32);
        check("frame1 frame_err", {31'd0, bus.frame_err}, 32'd0);

        // Frame resynchronised at sample 10
        base  = out_total;
        lbase = last_cnt;
        for (int i = 0; i < 42; i++) drive(1, (i == 0) || (i == 10), 100 + i, 3 * i, 0, 512);
        repeat (5) drive(0, 0, 0, 0, 0, 0);
        check("frame2 frame_err", {31'd0, bus.frame_err}, 32'd1);
        check("frame2 last count", 32'(last_cnt - lbase), 32'd1);
        check("frame2 last position", 32'(last_at - base), 32'd42);
        check("frame2 outputs", 32'(out_total - base), 32'd42);

        repeat (3) drive(0, 0, 0, 0, 0, 0);
        check("sticky frame_err", {31'd0, bus.frame_err}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
